// File: rtl/regfile_loader_pkg.sv
// ============================================================================
// Module : regfile_loader_pkg
// Purpose: Shared types and defaults for the register-file loader.
//          Holds the loader state encoding, default widths and the
//          saturation limit of the accepted-beat counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package regfile_loader_pkg;

  localparam int DEF_REG_BITS       = 5;
  localparam int DEF_DATA_BITS      = 32;
  localparam int DEF_CYC_BITS       = 10;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  localparam int LOAD_COUNT_BITS    = 6;
  localparam int LOAD_COUNT_MAX     = 63;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/loader_cycle_counter.sv
// ============================================================================
// Module : loader_cycle_counter
// Purpose: Clearable up-counter with a terminal-count flag. Used for the run
//          budget and for the idle timeout of the loader.
// Ports  : clock    - rising-edge clock
//          reset    - asynchronous active-low reset (count -> 0)
//          clear    - synchronous clear, wins over enable
//          enable   - count up by one on this edge
//          terminal - value at which tc is raised
//          tc       - count equals terminal (combinational)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module loader_cycle_counter #(
  parameter int WIDTH = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] terminal,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == terminal);

endmodule

`default_nettype wire

// File: rtl/regfile_loader.sv
// ============================================================================
// Module : regfile_loader
// Purpose: Preloads the processor register file from a host (index, value)
//          stream while holding the processor in reset, then runs the
//          processor for a programmed number of cycles and freezes the
//          register file by blocking all further writes.
// Macro  : LOADER_TIMEOUT_EN - when defined, an idle counter in LOAD forces
//          a release after TIMEOUT_CYCLES edges without an accepted beat and
//          raises the sticky timeout flag. When undefined, LOAD waits
//          indefinitely and timeout is tied low.
// Ports  : clock, reset(async, active-low)
//          in_valid/in_ready/in_reg/in_data/in_last - host load stream
//          num_cycles - run budget, sampled in RELEASE
//          cpu_reset  - active-high processor reset
//          cpu_we/cpu_wreg/cpu_wdata - processor write port (input side)
//          rf_we/rf_wreg/rf_wdata    - register file write port (output side)
//          load_count - accepted beats, saturating at 63
//          run_done   - budget exhausted, register file frozen
//          timeout    - forced release occurred
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_loader
  import regfile_loader_pkg::*;
#(
  parameter int REG_BITS       = DEF_REG_BITS,
  parameter int DATA_BITS      = DEF_DATA_BITS,
  parameter int CYC_BITS       = DEF_CYC_BITS,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [REG_BITS-1:0]        in_reg,
  input  logic [DATA_BITS-1:0]       in_data,
  input  logic                       in_last,
  input  logic [CYC_BITS-1:0]        num_cycles,
  output logic                       cpu_reset,
  input  logic                       cpu_we,
  input  logic [REG_BITS-1:0]        cpu_wreg,
  input  logic [DATA_BITS-1:0]       cpu_wdata,
  output logic                       rf_we,
  output logic [REG_BITS-1:0]        rf_wreg,
  output logic [DATA_BITS-1:0]       rf_wdata,
  output logic [LOAD_COUNT_BITS-1:0] load_count,
  output logic                       run_done,
  output logic                       timeout
);

  state_t              state;
  state_t              state_next;
  logic                accept;
  logic                run_tc;
  logic                idle_expire;
  logic [CYC_BITS-1:0] budget;

  assign accept = in_valid & in_ready;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      LOAD: begin
        if ((accept && in_last) || idle_expire) begin
          state_next = RELEASE;
        end
      end
      // num_cycles is being latched on this same edge, so decide on it directly
      RELEASE: state_next = (num_cycles == '0) ? DONE : RUN;
      RUN: begin
        if (run_tc) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = DONE;
      default: state_next = LOAD;
    endcase
  end

  // Output logic
  always_comb begin
    // reset is folded in so in_ready is low for the whole time reset is held
    in_ready  = (state == LOAD) && reset;
    cpu_reset = (state == LOAD) || (state == RELEASE);
    run_done  = (state == DONE);
    rf_we     = 1'b0;
    rf_wreg   = cpu_wreg;
    rf_wdata  = cpu_wdata;
    case (state)
      LOAD: begin
        // register 0 is hardwired, so beats to it are counted but not written
        rf_we    = accept && (in_reg != '0);
        rf_wreg  = in_reg;
        rf_wdata = in_data;
      end
      RUN:     rf_we = cpu_we;
      default: rf_we = 1'b0;
    endcase
  end

  // Accepted-beat counter, saturating
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      load_count <= '0;
    end else if (accept && (load_count != LOAD_COUNT_BITS'(LOAD_COUNT_MAX))) begin
      load_count <= load_count + 1'b1;
    end
  end

  // Run budget latch
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      budget <= '0;
    end else if (state == RELEASE) begin
      budget <= num_cycles;
    end
  end

  // Run counter starts at 0 on entry to RUN; leaving on count == budget-1
  // gives exactly budget rising edges in RUN.
  loader_cycle_counter #(
    .WIDTH (CYC_BITS)
  ) u_run_counter (
    .clock    (clock),
    .reset    (reset),
    .clear    (state != RUN),
    .enable   (state == RUN),
    .terminal (budget - 1'b1),
    .tc       (run_tc)
  );

`ifdef LOADER_TIMEOUT_EN
  localparam int IDLE_BITS = $clog2(TIMEOUT_CYCLES) + 1;

  logic idle_tc;
  logic timeout_flag;

  loader_cycle_counter #(
    .WIDTH (IDLE_BITS)
  ) u_idle_counter (
    .clock    (clock),
    .reset    (reset),
    .clear    ((state != LOAD) || accept),
    .enable   (state == LOAD),
    .terminal (IDLE_BITS'(TIMEOUT_CYCLES - 1)),
    .tc       (idle_tc)
  );

  // An accepted beat on the terminal edge restarts the idle window instead
  assign idle_expire = (state == LOAD) && idle_tc && !accept;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timeout_flag <= 1'b0;
    end else if (idle_expire) begin
      timeout_flag <= 1'b1;
    end
  end

  assign timeout = timeout_flag;
`else
  assign idle_expire = 1'b0;
  assign timeout     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_loader.sv
// ============================================================================
// Module : tb_regfile_loader
// Purpose: Self-checking bench for regfile_loader. Expected register-file
//          writes are queued as stimulus is driven and compared as the DUT
//          presents them; state-level outputs are compared against constants.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regfile_loader;

  localparam int REG_BITS  = 5;
  localparam int DATA_BITS = 32;
  localparam int CYC_BITS  = 10;
  localparam int TO_CYCLES = 16;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [REG_BITS-1:0]  in_reg = '0;
  logic [DATA_BITS-1:0] in_data = '0;
  logic                 in_last = 1'b0;
  logic [CYC_BITS-1:0]  num_cycles = '0;
  logic                 cpu_reset;
  logic                 cpu_we = 1'b0;
  logic [REG_BITS-1:0]  cpu_wreg = '0;
  logic [DATA_BITS-1:0] cpu_wdata = '0;
  logic                 rf_we;
  logic [REG_BITS-1:0]  rf_wreg;
  logic [DATA_BITS-1:0] rf_wdata;
  logic [5:0]           load_count;
  logic                 run_done;
  logic                 timeout;

  always #5 clock = ~clock;

  regfile_loader #(
    .REG_BITS       (REG_BITS),
    .DATA_BITS      (DATA_BITS),
    .CYC_BITS       (CYC_BITS),
    .TIMEOUT_CYCLES (TO_CYCLES)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_reg     (in_reg),
    .in_data    (in_data),
    .in_last    (in_last),
    .num_cycles (num_cycles),
    .cpu_reset  (cpu_reset),
    .cpu_we     (cpu_we),
    .cpu_wreg   (cpu_wreg),
    .cpu_wdata  (cpu_wdata),
    .rf_we      (rf_we),
    .rf_wreg    (rf_wreg),
    .rf_wdata   (rf_wdata),
    .load_count (load_count),
    .run_done   (run_done),
    .timeout    (timeout)
  );

  typedef struct packed {
    logic [REG_BITS-1:0]  r;
    logic [DATA_BITS-1:0] d;
  } wr_t;

  wr_t            exp_q[$];
  logic [31:0]    rf_model [32];
  int             vectors     = 0;
  int             miscompares = 0;
  int             run_edges   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Register file model: whatever the DUT writes lands here
  initial begin
    for (int i = 0; i < 32; i++) rf_model[i] = '0;
  end

  always @(posedge clock) begin
    if (rf_we) rf_model[rf_wreg] <= rf_wdata;
  end

  // Write monitor and RUN-cycle counter, sampled mid-cycle
  always @(negedge clock) begin
    wr_t e;
    if (reset && !cpu_reset && !run_done) run_edges++;
    if (rf_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {rf_wreg, rf_wdata}, 64'h0);
      end else begin
        e = exp_q.pop_front();
        check("wr_reg", rf_wreg, e.r);
        check("wr_data", rf_wdata, e.d);
      end
    end
  end

  // Drive phase is 1 time unit after each rising edge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_last  = 1'b0;
    cpu_we   = 1'b0;
    reset    = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    step();
  endtask

  task automatic beat(input logic [4:0] r, input logic [31:0] d, input logic last);
    in_valid = 1'b1;
    in_reg   = r;
    in_data  = d;
    in_last  = last;
    if (r != '0) exp_q.push_back({r, d});
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!run_done && n < budget) begin
      step();
      n++;
    end
    check("run_done_reached", run_done, 1);
  endtask

  initial begin
    int n;

    // Reset values, observed asynchronously before any clock edge
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    check("rst_in_ready", in_ready, 0);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_load_count", load_count, 0);
    check("rst_run_done", run_done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_rf_we", rf_we, 0);
    @(negedge clock);
    reset = 1'b1;
    step();

    // Two-beat load then a 3-cycle run
    check("load_ready", in_ready, 1);
    num_cycles = 10'd3;
    run_edges  = 0;
    beat(5'd1, 32'd5, 1'b0);
    beat(5'd2, 32'hFFFF_FFF9, 1'b1);
    check("rel_cpu_reset", cpu_reset, 1);
    check("rel_in_ready", in_ready, 0);
    check("rel_rf_we", rf_we, 0);
    check("rel_run_done", run_done, 0);
    wait_done(20);
    check("a_run_edges", run_edges, 3);
    check("a_r1", rf_model[1], 32'd5);
    check("a_r2", rf_model[2], 32'hFFFF_FFF9);
    check("a_load_count", load_count, 2);

    // Processor writes in DONE are blocked
    cpu_we    = 1'b1;
    cpu_wreg  = 5'd4;
    cpu_wdata = 32'd99;
    repeat (3) step();
    check("done_rf_we", rf_we, 0);
    check("done_cpu_reset", cpu_reset, 0);
    check("done_run_done", run_done, 1);
    check("done_r4", rf_model[4], 0);
    cpu_we = 1'b0;

    // Beat to r0 with a zero budget: straight from RELEASE to DONE
    do_reset();
    num_cycles = 10'd0;
    run_edges  = 0;
    beat(5'd0, 32'd123, 1'b1);
    check("r0_load_count", load_count, 1);
    check("r0_rel_cpu_reset", cpu_reset, 1);
    check("r0_rel_run_done", run_done, 0);
    step();
    check("r0_run_done", run_done, 1);
    check("r0_run_edges", run_edges, 0);
    check("r0_value", rf_model[0], 0);

    // 70 beats saturate the counter; host beats during RUN are ignored
    do_reset();
    num_cycles = 10'd4;
    run_edges  = 0;
    for (int i = 0; i < 70; i++) begin
      beat(5'((i % 31) + 1), 32'h1000 + 32'(i), (i == 69));
    end
    check("sat_load_count", load_count, 63);
    in_valid = 1'b1;
    in_reg   = 5'd3;
    in_data  = 32'hDEAD_BEEF;
    step();
    for (int i = 0; i < 4; i++) begin
      check("run_in_ready", in_ready, 0);
      check("run_cpu_reset", cpu_reset, 0);
      cpu_we    = 1'b1;
      cpu_wreg  = 5'(8 + i);
      cpu_wdata = 32'hC0DE_0000 + 32'(i);
      exp_q.push_back({cpu_wreg, cpu_wdata});
      step();
    end
    check("e_run_done", run_done, 1);
    check("e_run_edges", run_edges, 4);
    in_valid = 1'b0;
    cpu_we   = 1'b0;
    step();
    check("e_r1", rf_model[1], 32'h1000 + 32'd62);
    check("e_r9", rf_model[9], 32'hC0DE_0001);
    check("e_r3", rf_model[3], 32'h1000 + 32'd64);

    // Reset pulsed mid-RUN returns to LOAD immediately
    do_reset();
    num_cycles = 10'd10;
    beat(5'd5, 32'd55, 1'b1);
    step();
    repeat (2) step();
    check("f_in_run", cpu_reset, 0);
    cpu_we    = 1'b1;
    cpu_wreg  = 5'd6;
    cpu_wdata = 32'd66;
    reset     = 1'b0;
    #1;
    check("f_cpu_reset", cpu_reset, 1);
    check("f_in_ready", in_ready, 0);
    check("f_rf_we", rf_we, 0);
    check("f_load_count", load_count, 0);
    check("f_run_done", run_done, 0);
    cpu_we = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    step();
    check("f_load_ready", in_ready, 1);

`ifdef LOADER_TIMEOUT_EN
    // No beats: forced release after TO_CYCLES edges in LOAD
    do_reset();
    n = 1;
    while (in_ready && n < 100) begin
      step();
      n++;
    end
    check("to_edges", n, TO_CYCLES);
    check("to_timeout", timeout, 1);
    check("to_cpu_reset", cpu_reset, 1);
`else
    // No beats: LOAD waits indefinitely
    do_reset();
    n = 0;
    repeat (40) begin
      step();
      n++;
    end
    check("idle_in_ready", in_ready, 1);
    check("idle_timeout", timeout, 0);
`endif

    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
